lcd_reader: RTL and testbench
=============================

# lcd_reader

Read-side companion to the team's HD44780 4-bit LCD writer: performs `rw=1` reads over the same 4-bit bus (d4..d7) and returns either the busy-flag/address-counter byte (`rs=0`) or a DDRAM/CGRAM data byte (`rs=1`). It sits between the LCD sequencing logic and the pins. Its optional poll mode lets the writer wait on the busy flag instead of using fixed delays. The bus is bidirectional, so the block drives an output-enable for the d4..d7 pads and samples them through `lcd_d_in`.

## Interface
- `T_AS`, 4: clock cycles of rs/rw setup before the first `lcd_en` rise (≥1).
- `T_PW`, 24: `lcd_en` high width in cycles, per nibble (≥1).
- `T_GAP`, 50: `lcd_en` low cycles after each nibble (≥1).
- `POLL_MAX`, 4096: maximum byte reads in one poll transaction (≥1, 16-bit counter).

- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  read request.
- `req_rs`  in  1  0 = busy flag/address read, 1 = data read.
- `req_poll`  in  1  with `req_rs=0`: repeat reads until BF=0.
- `req_ready`  out  1  request accepted when `req_valid & req_ready`.
- `rd_valid`  out  1  one-cycle result strobe.
- `rd_data`  out  8  result byte; bit 7 = BF when `rs=0`.
- `timeout`  out  1  qualifies `rd_valid`: the poll limit was reached.
- `lcd_rs`, `lcd_rw`, `lcd_en`  out  1 each  LCD control pins.
- `lcd_d_in`  in  4  d7..d4 pad inputs, `{d7,d6,d5,d4}`.
- `lcd_d_oe`  out  1  1 = FPGA drives d4..d7; 0 = tristate.

## Operation
- States: IDLE → SETUP → HI1 → LO1 → HI2 → LO2 → (IDLE | HI1).
- IDLE:
  - `req_ready=1`, `lcd_rw=0`, `lcd_en=0`, `lcd_d_oe=1`.
  - On acceptance, latch `req_rs`. Latch the poll flag as `req_poll & ~req_rs`, so poll is ignored for data reads.
  - Go to SETUP and drive `lcd_rs`=latched rs, `lcd_rw=1`, `lcd_d_oe=0`, `req_ready=0`.
- SETUP: `T_AS` cycles with `lcd_en=0`.
- HI1 and HI2: `T_PW` cycles each with `lcd_en=1`.
  - On the clock edge that ends the last high cycle, register `lcd_d_in`.
  - HI1 captures the high nibble into `rd_data[7:4]`; HI2 captures the low nibble into `rd_data[3:0]`.
- LO1 and LO2: `T_GAP` cycles each with `lcd_en=0`. `lcd_rs` and `lcd_rw` hold for the whole transaction.
- End of LO2:
  - If poll is set, the assembled bit 7 is 1, and the poll count (incremented per completed byte) is < `POLL_MAX`: go to HI1 with no strobe.
  - Otherwise: `rd_valid=1` for one cycle, with `timeout = poll & BF & (count == POLL_MAX)`. Return to IDLE in the same cycle: `lcd_rw=0`, `lcd_d_oe=1`, `req_ready=1`.
- Holding rules:
  - `rd_data` is updated internally per nibble but holds its last value between transactions.
  - Bench checks `rd_data` only while `rd_valid=1`.
  - `req_valid` is ignored while `req_ready=0`.
- `lcd_d_oe` is never 1 while `lcd_rw=1`. `lcd_rw` never changes while `lcd_en=1`.

## Timing
- Reset values:
  - `req_ready=1`, `rd_valid=0`, `rd_data=0`, `timeout=0`.
  - `lcd_rs=0`, `lcd_rw=0`, `lcd_en=0`, `lcd_d_oe=1`.
  - State IDLE, poll count 0.
- Reset mid-operation: on the next edge all outputs take their reset values. `lcd_en` drops even mid-pulse. No `rd_valid`, and the transaction is discarded.
- Acceptance at edge 0:
  - `lcd_rw=1` in cycles 1..`T_AS`.
  - First `lcd_en` high in cycles `T_AS+1` .. `T_AS+T_PW`.
  - `rd_valid` in cycle `L = 1+T_AS+2·T_PW+2·T_GAP` (default 153).
- Each poll repeat adds `2·T_PW+2·T_GAP` cycles (default 148).
- Back-to-back: `req_ready` rises in the `rd_valid` cycle. A request held high is accepted on that edge, and its SETUP begins the next cycle, giving ≥`T_AS` rw setup with no gap state.
- Poll count resets to 0 on every acceptance. It saturates and is compared as an unsigned value.

## Test plan
- BF/AC read, defaults, `req_rs=0`, `lcd_d_in`=0x3 during HI1 and 0x5 during HI2 → `rd_valid` at cycle 153, `rd_data=0x35`, `timeout=0`. Check two `lcd_en` pulses of 24 cycles separated by 50 low, `lcd_rs=0`, and `lcd_rw=1` from cycle 1 to 152.
- Data read, `req_rs=1`, `req_poll=1`, nibbles 0xA/0xC → `rd_data=0xAC` at cycle 153, a single pass (poll ignored), `lcd_rs=1` throughout.
- Poll with `lcd_d_in`=0x8 for the first 3 bytes' high nibbles, then 0x0/0x7 → exactly one `rd_valid`, at cycle 153+3·148=597, `rd_data=0x07`, `timeout=0`.
- `POLL_MAX=2`, BF stuck 1 (nibbles 0x9/0x1) → `rd_valid` at cycle 301, `rd_data=0x91`, `timeout=1`.
- `rst` asserted during the second `lcd_en` pulse → next cycle `lcd_en=0`, `lcd_rw=0`, `lcd_d_oe=1`, `req_ready=1`, and no `rd_valid` ever appears.
- `req_valid` held high for 2 requests → second acceptance on the first `rd_valid` edge, second `rd_valid` at cycle 306. `req_valid` toggling mid-transaction has no effect.

Source files
------------

// File: rtl/lcd_reader.sv
// HD44780 4-bit read engine: busy-flag/address reads (rs=0) or data reads (rs=1),
// with optional busy-flag polling for the writer side.
// Ports: clk/rst; req_valid/req_rs/req_poll/req_ready request side;
//        rd_valid/rd_data/timeout result side; lcd_rs/lcd_rw/lcd_en pins,
//        lcd_d_in pad inputs {d7,d6,d5,d4}, lcd_d_oe pad output-enable.
module lcd_reader #(
    parameter int T_AS     = 4,
    parameter int T_PW     = 24,
    parameter int T_GAP    = 50,
    parameter int POLL_MAX = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic       req_rs,
    input  logic       req_poll,
    output logic       req_ready,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    output logic       timeout,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    input  logic [3:0] lcd_d_in,
    output logic       lcd_d_oe
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        HI1,
        LO1,
        HI2,
        LO2
    } state_t;

    localparam logic [15:0] AS_L  = 16'(T_AS - 1);
    localparam logic [15:0] PW_L  = 16'(T_PW - 1);
    localparam logic [15:0] GAP_L = 16'(T_GAP - 1);
    localparam logic [15:0] PMAX  = 16'(POLL_MAX);

    state_t      state;
    state_t      state_n;
    logic [15:0] tcnt;
    logic [15:0] tcnt_n;
    logic [15:0] pcnt;
    logic [15:0] pcnt_inc;
    logic        rs_q;
    logic        poll_q;
    logic        accept;
    logic        cap_hi;
    logic        cap_lo;
    logic        byte_end;
    logic        finish;
    logic        again;
    logic        tmo;

    // Poll count saturates rather than wrapping.
    assign pcnt_inc = (pcnt == 16'hFFFF) ? pcnt : pcnt + 16'd1;

    // BF (bit 7) was captured at the end of HI1, so it is valid here.
    assign again = poll_q & rd_data[7] & (pcnt_inc < PMAX);
    assign tmo   = poll_q & rd_data[7] & (pcnt_inc == PMAX);

    always_comb begin
        state_n   = state;
        tcnt_n    = tcnt + 16'd1;
        accept    = 1'b0;
        cap_hi    = 1'b0;
        cap_lo    = 1'b0;
        byte_end  = 1'b0;
        finish    = 1'b0;
        req_ready = 1'b0;
        lcd_rs    = rs_q;
        lcd_rw    = 1'b1;
        lcd_en    = 1'b0;
        lcd_d_oe  = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                lcd_rs    = 1'b0;
                lcd_rw    = 1'b0;
                lcd_d_oe  = 1'b1;
                tcnt_n    = 16'd0;
                if (req_valid) begin
                    accept  = 1'b1;
                    state_n = SETUP;
                end
            end
            SETUP: begin
                if (tcnt == AS_L) begin
                    state_n = HI1;
                    tcnt_n  = 16'd0;
                end
            end
            HI1: begin
                lcd_en = 1'b1;
                if (tcnt == PW_L) begin
                    cap_hi  = 1'b1;
                    state_n = LO1;
                    tcnt_n  = 16'd0;
                end
            end
            LO1: begin
                if (tcnt == GAP_L) begin
                    state_n = HI2;
                    tcnt_n  = 16'd0;
                end
            end
            HI2: begin
                lcd_en = 1'b1;
                if (tcnt == PW_L) begin
                    cap_lo  = 1'b1;
                    state_n = LO2;
                    tcnt_n  = 16'd0;
                end
            end
            LO2: begin
                if (tcnt == GAP_L) begin
                    byte_end = 1'b1;
                    tcnt_n   = 16'd0;
                    if (again) begin
                        state_n = HI1;
                    end else begin
                        finish  = 1'b1;
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tcnt     <= 16'd0;
            pcnt     <= 16'd0;
            rs_q     <= 1'b0;
            poll_q   <= 1'b0;
            rd_data  <= 8'h00;
            rd_valid <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_n;
            tcnt     <= tcnt_n;
            rd_valid <= finish;
            timeout  <= finish & tmo;
            if (accept) begin
                rs_q   <= req_rs;
                poll_q <= req_poll & ~req_rs;
                pcnt   <= 16'd0;
            end
            if (byte_end) begin
                pcnt <= pcnt_inc;
            end
            if (cap_hi) begin
                rd_data[7:4] <= lcd_d_in;
            end
            if (cap_lo) begin
                rd_data[3:0] <= lcd_d_in;
            end
        end
    end

endmodule

// File: tb/tb_lcd_reader.sv
// Directed bench for lcd_reader: a default instance and a POLL_MAX=2
// instance share a nibble-table LCD model that answers each lcd_en pulse.
module tb_lcd_reader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_rs = 1'b0;
    logic       req_poll = 1'b0;
    logic       sel = 1'b0;
    logic       tb_clr = 1'b0;
    logic [3:0] lcd_d_in;
    logic [3:0] nibs [16];
    logic [3:0] npulse = 4'd0;
    logic       en_prev = 1'b0;

    logic       rv0, rdy0, vld0, to0, rs0, rw0, en0, oe0;
    logic       rv1, rdy1, vld1, to1, rs1, rw1, en1, oe1;
    logic [7:0] dat0, dat1;
    logic       m_ready, m_valid, m_to, m_rs, m_rw, m_en, m_oe;
    logic [7:0] m_data;

    int checks = 0;
    int errors = 0;

    int v_cyc, v_data, v_to, end_rw, end_ready;
    int nrise, nfall;
    int rise [4];
    int fall [4];
    bit rw_ok, rs_ok, oe_ok;

    always #5 clk = ~clk;

    assign rv0 = req_valid & ~sel;
    assign rv1 = req_valid & sel;

    lcd_reader dut0 (
        .clk(clk), .rst(rst),
        .req_valid(rv0), .req_rs(req_rs), .req_poll(req_poll),
        .req_ready(rdy0), .rd_valid(vld0), .rd_data(dat0), .timeout(to0),
        .lcd_rs(rs0), .lcd_rw(rw0), .lcd_en(en0),
        .lcd_d_in(lcd_d_in), .lcd_d_oe(oe0)
    );

    lcd_reader #(.POLL_MAX(2)) dut1 (
        .clk(clk), .rst(rst),
        .req_valid(rv1), .req_rs(req_rs), .req_poll(req_poll),
        .req_ready(rdy1), .rd_valid(vld1), .rd_data(dat1), .timeout(to1),
        .lcd_rs(rs1), .lcd_rw(rw1), .lcd_en(en1),
        .lcd_d_in(lcd_d_in), .lcd_d_oe(oe1)
    );

    assign m_ready = sel ? rdy1 : rdy0;
    assign m_valid = sel ? vld1 : vld0;
    assign m_data  = sel ? dat1 : dat0;
    assign m_to    = sel ? to1  : to0;
    assign m_rs    = sel ? rs1  : rs0;
    assign m_rw    = sel ? rw1  : rw0;
    assign m_en    = sel ? en1  : en0;
    assign m_oe    = sel ? oe1  : oe0;

    // LCD model: pulse n of a transaction is answered with nibs[n].
    assign lcd_d_in = nibs[npulse];

    always @(negedge clk) begin
        if (tb_clr) begin
            npulse  <= 4'd0;
            en_prev <= 1'b0;
        end else begin
            if (en_prev && !m_en) npulse <= npulse + 4'd1;
            en_prev <= m_en;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_nibs(input logic [3:0] a, input logic [3:0] b,
                            input logic [3:0] c, input logic [3:0] d,
                            input logic [3:0] e, input logic [3:0] f,
                            input logic [3:0] g, input logic [3:0] h);
        nibs[0] = a; nibs[1] = b; nibs[2] = c; nibs[3] = d;
        nibs[4] = e; nibs[5] = f; nibs[6] = g; nibs[7] = h;
        for (int i = 8; i < 16; i++) nibs[i] = 4'h0;
    endtask

    task automatic clr_model();
        @(posedge clk);
        tb_clr = 1'b1;
        @(posedge clk);
        tb_clr = 1'b0;
    endtask

    // One transaction; cycle c is the c-th cycle after the accepting edge.
    task automatic run(input bit rs, input bit poll);
        bit pe;
        clr_model();
        @(negedge clk);
        req_valid = 1'b1;
        req_rs    = rs;
        req_poll  = poll;
        @(posedge clk);
        v_cyc = -1; v_data = -1; v_to = -1; end_rw = -1; end_ready = -1;
        nrise = 0; nfall = 0; rw_ok = 1; rs_ok = 1; oe_ok = 1; pe = 0;
        for (int i = 0; i < 4; i++) begin
            rise[i] = -1;
            fall[i] = -1;
        end
        for (int c = 1; c <= 2000; c++) begin
            @(negedge clk);
            if (c == 1) req_valid = 1'b0;
            if (m_valid) begin
                v_cyc = c;
                v_data = int'(m_data);
                v_to = int'(m_to);
                end_rw = int'(m_rw);
                end_ready = int'(m_ready);
                break;
            end
            if (!m_rw) rw_ok = 0;
            if (m_rs !== rs) rs_ok = 0;
            if (m_oe) oe_ok = 0;
            if (m_en && !pe) begin
                if (nrise < 4) rise[nrise] = c;
                nrise++;
            end
            if (!m_en && pe) begin
                if (nfall < 4) fall[nfall] = c;
                nfall++;
            end
            pe = m_en;
        end
    endtask

    initial begin
        int n;
        int vc [2];
        int vd [2];
        set_nibs(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_ready", int'(rdy0), 1);
        check("rst_valid", int'(vld0), 0);
        check("rst_data", int'(dat0), 0);
        check("rst_timeout", int'(to0), 0);
        check("rst_rs", int'(rs0), 0);
        check("rst_rw", int'(rw0), 0);
        check("rst_en", int'(en0), 0);
        check("rst_oe", int'(oe0), 1);

        set_nibs(4'h3, 4'h5, 0, 0, 0, 0, 0, 0);
        run(1'b0, 1'b0);
        check("bf_cycle", v_cyc, 153);
        check("bf_data", v_data, 'h35);
        check("bf_timeout", v_to, 0);
        check("bf_rise1", rise[0], 5);
        check("bf_fall1", fall[0], 29);
        check("bf_rise2", rise[1], 79);
        check("bf_fall2", fall[1], 103);
        check("bf_npulse", nrise, 2);
        check("bf_rs0", int'(rs_ok), 1);
        check("bf_rw_held", int'(rw_ok), 1);
        check("bf_oe_off", int'(oe_ok), 1);
        check("bf_end_rw", end_rw, 0);
        check("bf_end_ready", end_ready, 1);

        set_nibs(4'hA, 4'hC, 4'h0, 4'h0, 0, 0, 0, 0);
        run(1'b1, 1'b1);
        check("dat_cycle", v_cyc, 153);
        check("dat_data", v_data, 'hAC);
        check("dat_timeout", v_to, 0);
        check("dat_npulse", nrise, 2);
        check("dat_rs1", int'(rs_ok), 1);

        set_nibs(4'h8, 4'h0, 4'h8, 4'h0, 4'h8, 4'h0, 4'h0, 4'h7);
        run(1'b0, 1'b1);
        check("poll_cycle", v_cyc, 597);
        check("poll_data", v_data, 'h07);
        check("poll_timeout", v_to, 0);
        check("poll_npulse", nrise, 8);

        sel = 1'b1;
        set_nibs(4'h9, 4'h1, 4'h9, 4'h1, 4'h9, 4'h1, 4'h9, 4'h1);
        run(1'b0, 1'b1);
        check("pmax_cycle", v_cyc, 301);
        check("pmax_data", v_data, 'h91);
        check("pmax_timeout", v_to, 1);
        sel = 1'b0;

        set_nibs(4'h1, 4'h2, 4'h3, 4'h4, 0, 0, 0, 0);
        clr_model();
        @(negedge clk);
        req_valid = 1'b1;
        req_rs = 1'b0;
        req_poll = 1'b0;
        @(posedge clk);
        n = 0;
        vc[0] = -1; vc[1] = -1; vd[0] = -1; vd[1] = -1;
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            if (c == 154) req_valid = 1'b0;
            if (c >= 160 && c < 200) req_valid = c[0];
            if (c == 200) req_valid = 1'b0;
            if (m_valid) begin
                if (n < 2) begin
                    vc[n] = c;
                    vd[n] = int'(m_data);
                end
                n++;
            end
        end
        check("b2b_cycle1", vc[0], 153);
        check("b2b_cycle2", vc[1], 306);
        check("b2b_count", n, 2);
        check("b2b_data1", vd[0], 'h12);
        check("b2b_data2", vd[1], 'h34);

        set_nibs(4'hF, 4'hF, 0, 0, 0, 0, 0, 0);
        clr_model();
        @(negedge clk);
        req_valid = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 85; c++) begin
            @(negedge clk);
            if (c == 1) req_valid = 1'b0;
        end
        check("mid_en_high", int'(en0), 1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_en", int'(en0), 0);
        check("mid_rw", int'(rw0), 0);
        check("mid_oe", int'(oe0), 1);
        check("mid_ready", int'(rdy0), 1);
        check("mid_valid", int'(vld0), 0);
        rst = 1'b0;
        n = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (vld0) n++;
        end
        check("mid_no_valid", n, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
